flow_stat_rmw: RTL and testbench
================================

// Module: flow_stat_rmw
// PURPOSE
//  Per-flow statistics engine, fed by the rx write path and polled by the host read path.
//  Keeps a packet count and byte count per flow in an internal 2^A_WIDTH-entry array.
//  Each rx event does a read-modify-write. Each host read returns both counters and can clear them.
//  One shared array port; one operation in flight at a time; round-robin arbitration between paths.
// PARAMETERS
//  A_WIDTH  10  flow-number width; array depth = 2**A_WIDTH
//  D_WIDTH  32  width of each counter (pkt and byte)
// PORTS
//  clk_i          in   1        single clock, all logic rising-edge
//  rst_n_i        in   1        reset, asynchronous, active-low
//  rx_vld_i       in   1        rx event valid
//  rx_rdy_o       out  1        engine accepts rx event this cycle
//  rx_flow_num_i  in   A_WIDTH  flow index of rx event
//  pkt_size_i     in   16       packet size in bytes
//  rd_req_i       in   1        host read request
//  rd_rdy_o       out  1        engine accepts host read this cycle
//  rd_flow_num_i  in   A_WIDTH  flow index to read
//  rd_clr_i       in   1        clear both counters of the flow after reading
//  rd_vld_o       out  1        one-cycle pulse, read data valid
//  rd_pkt_cnt_o   out  D_WIDTH  packet count of the read flow
//  rd_byte_cnt_o  out  D_WIDTH  byte count of the read flow
//  init_done_o    out  1        array clear sweep finished
// BEHAVIOUR
//  Reset values (async assert): every output 0; state=INIT; sweep addr=0; prio=RX.
//  FSM states: INIT, IDLE, RD_MEM, UPD.
//   INIT: write {0,0} to addr 0..2**A_WIDTH-1, one entry per cycle.
//    On the last entry: init_done_o<=1, go to IDLE. init_done_o stays 1 until the next reset.
//   IDLE: accept at most one op, latch op type/flow/size/clr, go to RD_MEM.
//   RD_MEM: present the latched addr to the synchronous-read array; go to UPD.
//   UPD: the array data is now valid.
//    rx op: write {sat(pkt+1), sat(byte+pkt_size)}.
//    Host op: register both counters to the rd_*_cnt_o outputs and pulse rd_vld_o.
//     Write {0,0} if clr=1, else no write.
//    Go to IDLE.
//  Handshakes (combinational ready; transfer = vld/req & rdy on the same edge):
//   rx_rdy_o = IDLE & !(rd_req_i & prio==HOST)
//   rd_rdy_o = IDLE & !(rx_vld_i & prio==RX)
//   Only one of the two transfers occurs on any edge.
//   After an rx op completes, prio<=HOST; after a host op completes, prio<=RX.
//   Both readies are 0 in INIT, RD_MEM and UPD.
//  Throughput and latency:
//   One op per 3 cycles at most.
//   Host read accepted on edge N: rd_vld_o=1 and data valid in the cycle after edge N+2.
//   rd_*_cnt_o hold their value until the next host read completes.
//  Arithmetic:
//   pkt_size_i zero-extended to D_WIDTH.
//   Both adds saturate at 2**D_WIDTH-1; no wrap.
//   pkt_size_i=0 still increments pkt_cnt.
//  Ordering: ops are strictly serialised, so a read after an rx event to the same flow sees the update. No hazards.
//  Reset mid-op: op aborted, no array write, restart the INIT sweep from addr 0.
//   Any in-progress update is lost; all counters end at 0.
//  rd_clr_i is only sampled with an accepted rd_req_i.
// TESTING
//  1 Reset, count cycles -> init_done_o=1 exactly 1024 cycles after release. Both readies 0 until then.
//  2 rx flow 5 size 64, then size 1500; read flow 5 -> pkt=2, byte=1564, rd_vld_o 2 edges after accept.
//  3 rx_vld_i and rd_req_i held high continuously -> grants alternate rx/host/rx. Neither path starves.
//  4 Preload flow 7 to pkt=2**32-2 via rx events (or force) and add 2 events -> pkt=0xFFFF_FFFF. Byte count also saturates.
//  5 Read flow 3 with rd_clr_i=1 -> returns old counts. Re-read -> 0,0. Flow 4 unaffected.
//  6 Assert rst_n_i during UPD of an rx op -> outputs 0 at once; INIT resweeps; later read of that flow returns 0,0.

Source files
------------

// File: rtl/flow_stat_rmw_if.sv
// Request/response bundle between the rx path, the host read path and the flow statistics engine.
// Signal suffixes are seen from the engine side: _i is driven by the master, _o by the engine.
interface flow_stat_rmw_if #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32
);
  logic               rx_vld_i;
  logic               rx_rdy_o;
  logic [A_WIDTH-1:0] rx_flow_num_i;
  logic [15:0]        pkt_size_i;
  logic               rd_req_i;
  logic               rd_rdy_o;
  logic [A_WIDTH-1:0] rd_flow_num_i;
  logic               rd_clr_i;
  logic               rd_vld_o;
  logic [D_WIDTH-1:0] rd_pkt_cnt_o;
  logic [D_WIDTH-1:0] rd_byte_cnt_o;
  logic               init_done_o;

  modport master (
    output rx_vld_i, rx_flow_num_i, pkt_size_i,
    output rd_req_i, rd_flow_num_i, rd_clr_i,
    input  rx_rdy_o, rd_rdy_o, rd_vld_o, rd_pkt_cnt_o, rd_byte_cnt_o, init_done_o
  );

  modport slave (
    input  rx_vld_i, rx_flow_num_i, pkt_size_i,
    input  rd_req_i, rd_flow_num_i, rd_clr_i,
    output rx_rdy_o, rd_rdy_o, rd_vld_o, rd_pkt_cnt_o, rd_byte_cnt_o, init_done_o
  );
endinterface

// File: rtl/flow_stat_rmw.sv
// Per-flow packet/byte counters in a single-port synchronous RAM, updated by rx events
// with saturating read-modify-write and read (optionally cleared) by the host.
module flow_stat_rmw #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  flow_stat_rmw_if.slave  bus
);
  localparam int  DEPTH     = 2 ** A_WIDTH;
  localparam logic PRIO_RX   = 1'b0;
  localparam logic PRIO_HOST = 1'b1;

  typedef enum logic [1:0] {INIT, IDLE, RD_MEM, UPD} state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] sweep_q;
  logic               prio_q;
  logic               op_rx_q;
  logic [A_WIDTH-1:0] op_flow_q;
  logic [15:0]        op_size_q;
  logic               op_clr_q;
  logic               rd_vld_q;
  logic [D_WIDTH-1:0] rd_pkt_q;
  logic [D_WIDTH-1:0] rd_byte_q;
  logic               init_done_q;

  // Each word is {pkt_cnt, byte_cnt}; no reset so it maps onto block RAM.
  logic [2*D_WIDTH-1:0] mem_q [DEPTH];
  logic [2*D_WIDTH-1:0] mem_rdata_q;

  logic                 mem_we_d;
  logic [A_WIDTH-1:0]   mem_waddr_d;
  logic [2*D_WIDTH-1:0] mem_wdata_d;

  logic               rx_rdy;
  logic               rd_rdy;
  logic               rx_acc;
  logic               rd_acc;
  logic [D_WIDTH-1:0] cur_pkt;
  logic [D_WIDTH-1:0] cur_byte;
  logic [D_WIDTH:0]   pkt_sum;
  logic [D_WIDTH:0]   byte_sum;
  logic [D_WIDTH-1:0] pkt_sat_d;
  logic [D_WIDTH-1:0] byte_sat_d;

  assign rx_rdy = (state_q == IDLE) & ~(bus.rd_req_i & (prio_q == PRIO_HOST));
  assign rd_rdy = (state_q == IDLE) & ~(bus.rx_vld_i & (prio_q == PRIO_RX));
  assign rx_acc = bus.rx_vld_i & rx_rdy;
  assign rd_acc = bus.rd_req_i & rd_rdy & ~rx_acc;

  assign bus.rx_rdy_o      = rx_rdy;
  assign bus.rd_rdy_o      = rd_rdy;
  assign bus.rd_vld_o      = rd_vld_q;
  assign bus.rd_pkt_cnt_o  = rd_pkt_q;
  assign bus.rd_byte_cnt_o = rd_byte_q;
  assign bus.init_done_o   = init_done_q;

  // A carry out of the widened sum means the counter would wrap, so pin it at all-ones.
  assign cur_pkt    = mem_rdata_q[2*D_WIDTH-1:D_WIDTH];
  assign cur_byte   = mem_rdata_q[D_WIDTH-1:0];
  assign pkt_sum    = {1'b0, cur_pkt} + (D_WIDTH+1)'(1);
  assign byte_sum   = {1'b0, cur_byte} + (D_WIDTH+1)'(op_size_q);
  assign pkt_sat_d  = pkt_sum[D_WIDTH]  ? '1 : pkt_sum[D_WIDTH-1:0];
  assign byte_sat_d = byte_sum[D_WIDTH] ? '1 : byte_sum[D_WIDTH-1:0];

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = op_flow_q;
    mem_wdata_d = '0;
    case (state_q)
      INIT: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = sweep_q;
      end
      UPD: begin
        if (op_rx_q) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = {pkt_sat_d, byte_sat_d};
        end else if (op_clr_q) begin
          mem_we_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset forces state_q to INIT, so a pending update turns into a harmless sweep write.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
    mem_rdata_q <= mem_q[op_flow_q];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      prio_q      <= PRIO_RX;
      op_rx_q     <= 1'b0;
      op_flow_q   <= '0;
      op_size_q   <= '0;
      op_clr_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_pkt_q    <= '0;
      rd_byte_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == '1) begin
            init_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          if (rx_acc) begin
            op_rx_q   <= 1'b1;
            op_flow_q <= bus.rx_flow_num_i;
            op_size_q <= bus.pkt_size_i;
            op_clr_q  <= 1'b0;
            state_q   <= RD_MEM;
          end else if (rd_acc) begin
            op_rx_q   <= 1'b0;
            op_flow_q <= bus.rd_flow_num_i;
            op_size_q <= '0;
            op_clr_q  <= bus.rd_clr_i;
            state_q   <= RD_MEM;
          end
        end
        RD_MEM: begin
          state_q <= UPD;
        end
        UPD: begin
          if (op_rx_q) begin
            prio_q <= PRIO_HOST;
          end else begin
            prio_q    <= PRIO_RX;
            rd_vld_q  <= 1'b1;
            rd_pkt_q  <= cur_pkt;
            rd_byte_q <= cur_byte;
          end
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_flow_stat_rmw.sv
// Scoreboard bench for flow_stat_rmw: a reference counter array predicts every host read result.
`timescale 1ns/1ps
module tb_flow_stat_rmw;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flow_stat_rmw_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  flow_stat_rmw #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]   m_pkt  [2**AW];
  logic [DW-1:0]   m_byte [2**AW];
  logic [2*DW-1:0] exp_q  [$];
  int              acc_cyc;
  bit              acc_ok;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) begin
      m_pkt[i]  = '0;
      m_byte[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic send_rx(input logic [AW-1:0] flow, input logic [15:0] size);
    bit r;
    acc_ok = 0;
    @(negedge clk);
    bus.rx_vld_i      = 1'b1;
    bus.rx_flow_num_i = flow;
    bus.pkt_size_i    = size;
    for (int t = 0; t < 50; t++) begin
      #1 r = bus.rx_rdy_o;
      @(posedge clk);
      if (r) begin
        acc_ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1 bus.rx_vld_i = 1'b0;
    if (acc_ok) begin
      m_pkt[flow]  = sat_add(m_pkt[flow], 1);
      m_byte[flow] = sat_add(m_byte[flow], {16'd0, size});
    end else begin
      n_vec++; n_err++;
      $display("FAIL rx_accept_timeout flow=%0d: rx_rdy_o never 1, required 1 within 50 cycles", flow);
    end
  endtask

  task automatic send_rd(input logic [AW-1:0] flow, input logic clr);
    bit r;
    acc_ok = 0;
    @(negedge clk);
    bus.rd_req_i      = 1'b1;
    bus.rd_flow_num_i = flow;
    bus.rd_clr_i      = clr;
    for (int t = 0; t < 50; t++) begin
      #1 r = bus.rd_rdy_o;
      @(posedge clk);
      if (r) begin
        acc_ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    acc_cyc      = cyc;
    bus.rd_req_i = 1'b0;
    bus.rd_clr_i = 1'b0;
    if (acc_ok) begin
      exp_q.push_back({m_pkt[flow], m_byte[flow]});
      if (clr) begin
        m_pkt[flow]  = '0;
        m_byte[flow] = '0;
      end
    end else begin
      n_vec++; n_err++;
      $display("FAIL rd_accept_timeout flow=%0d: rd_rdy_o never 1, required 1 within 50 cycles", flow);
    end
  endtask

  task automatic wait_vld(output bit ok);
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (bus.rd_vld_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  cnt;
    bit  rdy_bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.rd_vld_o, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, bus.init_done_o, bus.rx_rdy_o, bus.rd_rdy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: vld=%b pkt=%h byte=%h done=%b rxr=%b rdr=%b, required all 0",
               bus.rd_vld_o, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, bus.init_done_o, bus.rx_rdy_o, bus.rd_rdy_o);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    cnt     = 0;
    rdy_bad = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.init_done_o) break;
      if (bus.rx_rdy_o || bus.rd_rdy_o) rdy_bad = 1;
    end
    n_vec++;
    if (!bus.init_done_o || cnt != 1024) begin
      n_err++;
      $display("FAIL init_sweep_cycles: done=%b after %0d edges, required 1 after 1024", bus.init_done_o, cnt);
    end
    n_vec++;
    if (rdy_bad) begin
      n_err++;
      $display("FAIL init_readies: ready seen high during INIT, required 0");
    end
    model_clear();
    $display("reset: init_done after %0d edges", cnt);
  endtask

  task automatic test_basic();
    bit ok;
    logic [2*DW-1:0] e;
    send_rx(5, 16'd64);
    send_rx(5, 16'd1500);
    send_rd(5, 1'b0);
    if (!acc_ok) return;
    wait_vld(ok);
    n_vec++;
    if (!ok || (cyc - acc_cyc) != 2) begin
      n_err++;
      $display("FAIL basic_latency: vld=%b at %0d edges after accept, required 1 at 2", ok, cyc - acc_cyc);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e || e !== {32'd2, 32'd1564}) begin
      n_err++;
      $display("FAIL basic_counts: pkt=%0d byte=%0d, required pkt=%0d byte=%0d",
               bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.rd_vld_o !== 1'b0 || bus.rd_pkt_cnt_o !== 32'd2) begin
      n_err++;
      $display("FAIL basic_hold: vld=%b pkt=%0d, required vld=0 pkt=2", bus.rd_vld_o, bus.rd_pkt_cnt_o);
    end
    $display("basic: flow 5 pkt=%0d byte=%0d", bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o);
  endtask

  task automatic test_arbitration();
    bit rr, hr;
    int g, last_g, n_r, n_h;
    logic [2*DW-1:0] e;
    last_g = -1; n_r = 0; n_h = 0;
    @(negedge clk);
    bus.rx_flow_num_i = 9;
    bus.pkt_size_i    = 16'd10;
    bus.rd_flow_num_i = 9;
    bus.rd_clr_i      = 1'b0;
    bus.rx_vld_i      = 1'b1;
    bus.rd_req_i      = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      rr = bus.rx_rdy_o;
      hr = bus.rd_rdy_o;
      @(posedge clk);
      if (rr) begin
        m_pkt[9]  = sat_add(m_pkt[9], 1);
        m_byte[9] = sat_add(m_byte[9], 10);
      end
      if (hr) exp_q.push_back({m_pkt[9], m_byte[9]});
      if (rr || hr) begin
        g = rr ? 0 : 1;
        n_vec++;
        if ((rr && hr) || g == last_g) begin
          n_err++;
          $display("FAIL arb_alternate cycle %0d: rx_grant=%b host_grant=%b prev=%0d, required single grant differing from prev",
                   c, rr, hr, last_g);
        end
        last_g = g;
        if (rr) n_r++; else n_h++;
      end
      #1;
      if (bus.rd_vld_o && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e) begin
          n_err++;
          $display("FAIL arb_read_data: pkt=%0d byte=%0d, required pkt=%0d byte=%0d",
                   bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
      @(negedge clk);
    end
    bus.rx_vld_i = 1'b0;
    bus.rd_req_i = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      @(posedge clk); #1;
      if (bus.rd_vld_o) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e) begin
          n_err++;
          $display("FAIL arb_drain_data: pkt=%0d byte=%0d, required pkt=%0d byte=%0d",
                   bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
    n_vec++;
    if (n_r < 4 || n_h < 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL arb_fairness: rx=%0d host=%0d pending=%0d, required >=4, >=4, 0", n_r, n_h, exp_q.size());
    end
    $display("arbitration: %0d rx grants, %0d host grants", n_r, n_h);
  endtask

  task automatic test_saturation();
    bit ok;
    logic [2*DW-1:0] e;
    @(negedge clk);
    dut.mem_q[7] = {32'hFFFF_FFFE, 32'hFFFF_FF00};
    m_pkt[7]  = 32'hFFFF_FFFE;
    m_byte[7] = 32'hFFFF_FF00;
    send_rx(7, 16'h0080);
    send_rx(7, 16'h0100);
    send_rx(8, 16'd0);
    for (int k = 0; k < 2; k++) begin
      send_rd((k == 0) ? 10'd7 : 10'd8, 1'b0);
      if (!acc_ok) continue;
      wait_vld(ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || {bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e) begin
        n_err++;
        $display("FAIL sat_counts flow=%0d: vld=%b pkt=%h byte=%h, required pkt=%h byte=%h",
                 (k == 0) ? 7 : 8, ok, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
      end
      $display("saturation: flow %0d pkt=%h byte=%h", (k == 0) ? 7 : 8, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o);
    end
  endtask

  task automatic test_clear();
    bit ok;
    logic [2*DW-1:0] e;
    logic [AW-1:0] flows [3];
    logic          clrs  [3];
    flows[0] = 3; clrs[0] = 1'b1;
    flows[1] = 3; clrs[1] = 1'b0;
    flows[2] = 4; clrs[2] = 1'b0;
    send_rx(3, 16'd100);
    send_rx(3, 16'd200);
    send_rx(4, 16'd50);
    for (int k = 0; k < 3; k++) begin
      send_rd(flows[k], clrs[k]);
      if (!acc_ok) continue;
      wait_vld(ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || {bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e) begin
        n_err++;
        $display("FAIL clear_read%0d flow=%0d: vld=%b pkt=%0d byte=%0d, required pkt=%0d byte=%0d",
                 k, flows[k], ok, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
      end
      $display("clear: read flow %0d clr=%b pkt=%0d byte=%0d", flows[k], clrs[k], bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    logic [2*DW-1:0] e;
    int cnt;
    send_rx(11, 16'd5);
    send_rx(11, 16'd9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rd_vld_o, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, bus.init_done_o, bus.rx_rdy_o, bus.rd_rdy_o} !== '0) begin
      n_err++;
      $display("FAIL midop_reset_outputs: pkt=%h byte=%h done=%b, required all 0",
               bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, bus.init_done_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.init_done_o) break;
    end
    n_vec++;
    if (cnt != 1024 || !bus.init_done_o) begin
      n_err++;
      $display("FAIL midop_resweep: done=%b after %0d edges, required 1 after 1024", bus.init_done_o, cnt);
    end
    model_clear();
    for (int k = 0; k < 2; k++) begin
      send_rd((k == 0) ? 10'd11 : 10'd5, 1'b0);
      if (!acc_ok) continue;
      wait_vld(ok);
      e = exp_q.pop_front();
      n_vec++;
      if (!ok || {bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o} !== e) begin
        n_err++;
        $display("FAIL midop_counts flow=%0d: vld=%b pkt=%0d byte=%0d, required pkt=%0d byte=%0d",
                 (k == 0) ? 11 : 5, ok, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o, e[2*DW-1:DW], e[DW-1:0]);
      end
      $display("reset_mid_op: flow %0d pkt=%0d byte=%0d", (k == 0) ? 11 : 5, bus.rd_pkt_cnt_o, bus.rd_byte_cnt_o);
    end
  endtask

  initial begin
    bus.rx_vld_i      = 1'b0;
    bus.rx_flow_num_i = '0;
    bus.pkt_size_i    = '0;
    bus.rd_req_i      = 1'b0;
    bus.rd_flow_num_i = '0;
    bus.rd_clr_i      = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_arbitration();
    test_saturation();
    test_clear();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
